// File: rtl/parking_lane_counter_pkg.sv
// Shared types and helpers for the multi-lane parking counter.
// Lane state encoding, sensor codes and a width helper.
package parking_lane_counter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_E1,
      ST_E2,
      ST_E3,
      ST_X1,
      ST_X2,
      ST_X3,
      ST_WAIT
   } lane_st_e;

   localparam logic [1:0] S00 = 2'b00;
   localparam logic [1:0] S10 = 2'b10;
   localparam logic [1:0] S11 = 2'b11;
   localparam logic [1:0] S01 = 2'b01;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/parking_lane_counter_lane_dir_detector.sv
// One lane: sync, debounce, direction FSM and stuck-sequence timeout.
// Emits one-cycle registered entry/exit pulses.
module lane_dir_detector
   import parking_lane_counter_pkg::*;
#(
   parameter int DEB_CYC = 4,
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic sumar,
   output logic restar
);

   localparam int DW = clog2(DEB_CYC + 1);
   localparam int TW = clog2(TIMEOUT + 1);

   logic [1:0] s1_q, s2_q, filt_q, filt_d;
   logic [1:0][DW-1:0] deb_q, deb_d;
   lane_st_e st_q, st_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic sum_q, sum_d, res_q, res_d;
   logic tmo;

   always_comb begin
      filt_d = filt_q;
      deb_d = deb_q;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == filt_q[i]) begin
            deb_d[i] = '0;
         end else if (deb_q[i] == DW'(DEB_CYC - 1)) begin
            filt_d[i] = s2_q[i];
            deb_d[i] = '0;
         end else begin
            deb_d[i] = deb_q[i] + 1'b1;
         end
      end
   end

   assign tmo = (tmr_q == TW'(TIMEOUT))
             && (st_q != ST_IDLE)
             && (st_q != ST_WAIT);

   always_comb begin
      st_d = st_q;
      sum_d = 1'b0;
      res_d = 1'b0;
      if (!en) begin
         st_d = ST_IDLE;
      end else if (filt_q == S00) begin
         st_d = ST_IDLE;
         sum_d = (st_q == ST_E3);
         res_d = (st_q == ST_X3);
      end else if (tmo) begin
         st_d = ST_WAIT;
      end else begin
         unique case (st_q)
            ST_IDLE: begin
               if (filt_q == S10) st_d = ST_E1;
               else if (filt_q == S01) st_d = ST_X1;
               else st_d = ST_WAIT;
            end
            ST_E1: begin
               if (filt_q == S11) st_d = ST_E2;
               else if (filt_q == S01) st_d = ST_WAIT;
            end
            ST_E2: begin
               if (filt_q == S01) st_d = ST_E3;
               else if (filt_q == S10) st_d = ST_E1;
            end
            ST_E3: begin
               if (filt_q == S11) st_d = ST_E2;
               else if (filt_q == S10) st_d = ST_WAIT;
            end
            ST_X1: begin
               if (filt_q == S11) st_d = ST_X2;
               else if (filt_q == S10) st_d = ST_WAIT;
            end
            ST_X2: begin
               if (filt_q == S10) st_d = ST_X3;
               else if (filt_q == S01) st_d = ST_X1;
            end
            ST_X3: begin
               if (filt_q == S11) st_d = ST_X2;
               else if (filt_q == S01) st_d = ST_WAIT;
            end
            ST_WAIT: st_d = ST_WAIT;
         endcase
      end
   end

   // Saturate so a long dwell in IDLE/WAIT cannot wrap.
   always_comb begin
      if (!en || (st_d != st_q)) tmr_d = '0;
      else if (tmr_q == TW'(TIMEOUT)) tmr_d = tmr_q;
      else tmr_d = tmr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
         filt_q <= '0;
         deb_q <= '0;
         st_q <= ST_IDLE;
         tmr_q <= '0;
         sum_q <= 1'b0;
         res_q <= 1'b0;
      end else begin
         s1_q <= {a, b};
         s2_q <= s1_q;
         filt_q <= filt_d;
         deb_q <= deb_d;
         st_q <= st_d;
         tmr_q <= tmr_d;
         sum_q <= sum_d;
         res_q <= res_d;
      end
   end

   assign sumar = sum_q;
   assign restar = res_q;

endmodule

// File: rtl/parking_lane_counter.sv
// Multi-lane parking occupancy counter with saturation flags.
// Lane pulses are netted each cycle into one registered count.
module parking_lane_counter
   import parking_lane_counter_pkg::*;
#(
   parameter int LANES = 2,
   parameter int CNT_W = 8,
   parameter int CAPACITY = 100,
   parameter int DEB_CYC = 4,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [LANES-1:0] a,
   input  logic [LANES-1:0] b,
   output logic [LANES-1:0] sumar,
   output logic [LANES-1:0] restar,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             udf
);

   localparam int NW = CNT_W + clog2(LANES) + 2;
   localparam logic signed [NW-1:0] CAP_S = NW'(CAPACITY);

   logic [CNT_W-1:0] count_q, count_d;
   logic ovf_q, ovf_d, udf_q, udf_d;
   logic signed [NW-1:0] net;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_dir_detector #(
         .DEB_CYC(DEB_CYC),
         .TIMEOUT(TIMEOUT)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .en    (en),
         .a     (a[g]),
         .b     (b[g]),
         .sumar (sumar[g]),
         .restar(restar[g])
      );
   end

   always_comb begin
      net = $signed(NW'(count_q));
      for (int i = 0; i < LANES; i++) begin
         net = net + $signed(NW'(sumar[i]))
                   - $signed(NW'(restar[i]));
      end
   end

   always_comb begin
      count_d = count_q;
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (clr) begin
         count_d = '0;
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end else if (net > CAP_S) begin
         count_d = CNT_W'(CAPACITY);
         ovf_d = 1'b1;
      end else if (net[NW-1]) begin
         count_d = '0;
         udf_d = 1'b1;
      end else begin
         count_d = net[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign count = count_q;
   assign full = (count_q == CNT_W'(CAPACITY));
   assign empty = (count_q == '0);
   assign ovf = ovf_q;
   assign udf = udf_q;

endmodule

// File: tb/tb_parking_lane_counter.sv
// Directed bench for parking_lane_counter (2 lanes, capacity 3).
// Expected lane pulses are queued at stimulus time and matched on arrival.
module tb_parking_lane_counter;

   logic clk = 1'b0;
   logic rst, en, clr;
   logic [1:0] a, b, sumar, restar;
   logic [7:0] count;
   logic full, empty, ovf, udf;

   int tests = 0;
   int fails = 0;
   logic [3:0] exp_q[$];

   localparam logic [7:0] ENT = 8'b10_11_01_00;
   localparam logic [7:0] EXT = 8'b01_11_10_00;
   localparam logic [7:0] NON = 8'b00_00_00_00;
   localparam logic [7:0] PD1 = 8'b10_01_00_00;
   localparam logic [7:0] PD2 = 8'b01_10_00_00;

   parking_lane_counter #(
      .LANES(2), .CNT_W(8), .CAPACITY(3),
      .DEB_CYC(4), .TIMEOUT(50)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .a(a), .b(b), .sumar(sumar), .restar(restar),
      .count(count), .full(full), .empty(empty),
      .ovf(ovf), .udf(udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [15:0] got,
                      input logic [15:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {sumar, restar} is matched against the queue on every pulse.
   always @(negedge clk) begin
      if ((sumar | restar) != 2'b00) begin
         if (exp_q.size() == 0)
            chk("unexpected_pulse", {12'h0, sumar, restar}, 16'h0);
         else
            chk("pulse", {12'h0, sumar, restar}, {12'h0, exp_q.pop_front()});
      end
   end

   task automatic drive(input logic [1:0] c0,
                        input logic [1:0] c1,
                        input int n);
      a = {c1[1], c0[1]};
      b = {c1[0], c0[0]};
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic play(input logic [7:0] c0, input logic [7:0] c1);
      for (int i = 3; i >= 0; i--) drive(c0[2*i +: 2], c1[2*i +: 2], 10);
      drive(2'b00, 2'b00, 15);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; clr = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sumar", {14'h0, sumar}, 16'h0);
      chk("rst_restar", {14'h0, restar}, 16'h0);
      chk("rst_count", {8'h0, count}, 16'd0);
      chk("rst_empty", {15'h0, empty}, 16'd1);
      chk("rst_full", {15'h0, full}, 16'd0);
      chk("rst_ovf", {15'h0, ovf}, 16'd0);
      chk("rst_udf", {15'h0, udf}, 16'd0);
      rst = 1'b1;
      drive(2'b00, 2'b00, 5);

      exp_q.push_back(4'b01_00);
      play(ENT, NON);
      chk("entry_count", {8'h0, count}, 16'd1);
      chk("entry_empty", {15'h0, empty}, 16'd0);
      chk("entry_queue", 16'(exp_q.size()), 16'd0);

      exp_q.push_back(4'b00_01);
      play(EXT, NON);
      chk("exit_count", {8'h0, count}, 16'd0);
      chk("exit_empty", {15'h0, empty}, 16'd1);
      chk("exit_udf", {15'h0, udf}, 16'd0);

      exp_q.push_back(4'b00_10);
      play(NON, EXT);
      chk("udf_count", {8'h0, count}, 16'd0);
      chk("udf_flag", {15'h0, udf}, 16'd1);
      pulse_clr();
      chk("clr_udf", {15'h0, udf}, 16'd0);

      play(NON, PD1);
      play(NON, PD2);
      chk("ped_count", {8'h0, count}, 16'd0);
      exp_q.push_back(4'b10_00);
      play(NON, ENT);
      chk("ped_then_entry", {8'h0, count}, 16'd1);

      // Dropout one sample short of the debounce window, mid-entry.
      exp_q.push_back(4'b01_00);
      drive(2'b10, 2'b00, 10);
      drive(2'b00, 2'b00, 3);
      drive(2'b10, 2'b00, 7);
      drive(2'b11, 2'b00, 10);
      drive(2'b01, 2'b00, 10);
      drive(2'b00, 2'b00, 15);
      chk("glitch_count", {8'h0, count}, 16'd2);
      chk("glitch_queue", 16'(exp_q.size()), 16'd0);

      drive(2'b10, 2'b00, 10);
      drive(2'b11, 2'b00, 10);
      en = 1'b0;
      drive(2'b11, 2'b00, 10);
      en = 1'b1;
      drive(2'b01, 2'b00, 10);
      drive(2'b00, 2'b00, 15);
      chk("en_low_count", {8'h0, count}, 16'd2);

      pulse_clr();
      chk("clr_count", {8'h0, count}, 16'd0);
      exp_q.push_back(4'b11_00);
      play(ENT, ENT);
      chk("dual_count", {8'h0, count}, 16'd2);
      exp_q.push_back(4'b01_00);
      play(ENT, NON);
      chk("fill_count", {8'h0, count}, 16'd3);
      chk("fill_full", {15'h0, full}, 16'd1);
      chk("fill_ovf", {15'h0, ovf}, 16'd0);
      exp_q.push_back(4'b11_00);
      play(ENT, ENT);
      chk("sat_count", {8'h0, count}, 16'd3);
      chk("sat_ovf", {15'h0, ovf}, 16'd1);
      pulse_clr();
      chk("clr2_count", {8'h0, count}, 16'd0);
      chk("clr2_ovf", {15'h0, ovf}, 16'd0);
      chk("clr2_empty", {15'h0, empty}, 16'd1);

      exp_q.push_back(4'b11_00);
      play(ENT, ENT);
      exp_q.push_back(4'b01_00);
      play(ENT, NON);
      exp_q.push_back(4'b01_10);
      play(ENT, EXT);
      chk("net_count", {8'h0, count}, 16'd3);
      chk("net_ovf", {15'h0, ovf}, 16'd0);
      chk("net_udf", {15'h0, udf}, 16'd0);
      chk("net_full", {15'h0, full}, 16'd1);

      drive(2'b10, 2'b00, 60);
      drive(2'b11, 2'b00, 10);
      drive(2'b01, 2'b00, 10);
      drive(2'b00, 2'b00, 15);
      chk("timeout_count", {8'h0, count}, 16'd3);
      chk("timeout_queue", 16'(exp_q.size()), 16'd0);

      drive(2'b10, 2'b00, 10);
      drive(2'b11, 2'b00, 10);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_count", {8'h0, count}, 16'd0);
      chk("arst_empty", {15'h0, empty}, 16'd1);
      chk("arst_full", {15'h0, full}, 16'd0);
      chk("arst_pulses", {12'h0, sumar, restar}, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      drive(2'b01, 2'b00, 10);
      drive(2'b00, 2'b00, 15);
      chk("arst_lost_seq", {8'h0, count}, 16'd0);
      chk("final_queue", 16'(exp_q.size()), 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/parking_lane_counter.md
Name: parking_lane_counter

Overview:
- Multi-lane successor to the single two-sensor direction FSM. Each lane has a sensor pair (a, b) and decodes vehicle entry and exit sequences. Sequences that are partial or pedestrian-like are rejected.
- Adds input synchronisation, debounce, a stuck-sequence timeout, and a shared saturating occupancy counter with full/empty flags.
- Sits between the raw barrier sensors and the display/barrier-control logic.

Parameters:
- LANES, 2, number of independent sensor pairs
- CNT_W, 8, occupancy counter width
- CAPACITY, 100, maximum occupancy; must be less than 2^CNT_W
- DEB_CYC, 4, consecutive stable synchronised samples needed before a filtered input changes
- TIMEOUT, 1000, cycles allowed in any non-IDLE lane state before abort

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (clk/rst as already decided)
- en  in  1  when low, lane FSMs are forced to IDLE and no pulses are issued; debouncers keep running
- clr  in  1  synchronous clear of count and sticky flags
- a  in  LANES  outer sensor per lane (1 = beam blocked)
- b  in  LANES  inner sensor per lane
- sumar  out  LANES  one-cycle entry pulse per lane
- restar  out  LANES  one-cycle exit pulse per lane
- count  out  CNT_W  current occupancy
- full  out  1  count == CAPACITY
- empty  out  1  count == 0
- ovf  out  1  sticky: an entry was rejected by saturation
- udf  out  1  sticky: an exit was rejected at zero

Behaviour:
- Reset values: sumar=0, restar=0, count=0, empty=1, full=0, ovf=0, udf=0. All lane FSMs in IDLE. Filtered inputs=00. Synchronisers and debounce counters cleared.
- Input path per bit:
  - 2-FF synchroniser.
  - Debounce counter: the filtered value takes the synchronised value only after DEB_CYC consecutive equal samples that differ from the current filtered value.
  - Latency from raw edge to filtered edge: 2+DEB_CYC cycles.
- Lane FSM operates on the filtered pair {a,b}. States: IDLE, E1, E2, E3, X1, X2, X3, WAIT.
- Entry path:
  - IDLE on 10 -> E1
  - E1 on 11 -> E2
  - E2 on 01 -> E3
  - E3 on 00 -> IDLE, and sumar pulses next cycle
- Exit path (mirror):
  - IDLE on 01 -> X1
  - X1 on 11 -> X2
  - X2 on 10 -> X3
  - X3 on 00 -> IDLE, and restar pulses next cycle
- Back-off, no count:
  - E2 on 10 -> E1; E3 on 11 -> E2
  - X2 on 01 -> X1; X3 on 11 -> X2
- Return to IDLE without a pulse: 00 in any state other than E3 or X3 (this covers pedestrians and partial passes).
- Illegal jumps go to WAIT:
  - IDLE on 11
  - E1 on 01; X1 on 10
  - E3 on 10; X3 on 01
- WAIT leaves only on 00, returning to IDLE with no pulse.
- Unchanged input: stay in the current state.
- Timeout:
  - A per-lane counter resets on every state change.
  - Reaching TIMEOUT in any state other than IDLE or WAIT forces WAIT, with no pulse.
- en low: all FSMs and timeout counters are held in IDLE/0. Any sequence in progress is discarded.
- Counter update (registered; count changes the cycle after the pulses):
  - next = count + popcount(sumar) − popcount(restar), evaluated in signed CNT_W+clog2(LANES)+2 bits.
  - If next > CAPACITY: count=CAPACITY and ovf←1.
  - If next < 0: count=0 and udf←1.
  - Otherwise count=next.
  - Simultaneous pulses on different lanes net out in the same cycle. For example, +1 and −1 when full gives no change and no flag.
- full and empty are combinational from count.
- Pulses are issued even when count saturates.
- clr has priority: count=0, ovf=udf=0, and pulses in that cycle are ignored by the counter. clr does not affect lane FSMs.
- Reset mid-sequence: everything returns to reset values immediately; a partial sequence is lost.

Decomposition:
- Shared package holds:
  - lane state encoding (3-bit enum for IDLE..WAIT)
  - sensor-code constants S00/S10/S11/S01
  - the clog2 helper
- Natural sub-module `lane_dir_detector`: synchroniser, debounce, FSM and timeout for one lane. It is instantiated LANES times via generate.
- The top level contains only the net-sum and saturating counter.

Test Plan (LANES=2, DEB_CYC=4, TIMEOUT=50, CAPACITY=3; each sensor code held 10 cycles):
- Lane0 applies 00,10,11,01,00 -> exactly one sumar[0] pulse about 7 cycles after the final 00; count 0->1; empty falls.
- Lane0 applies 00,01,11,10,00 from count=1 -> one restar[0] pulse; count=0; empty=1; no udf.
- Pedestrian on lane1: 00,10,01,00, then 00,01,10,00 -> no pulses; count unchanged; FSM passes through WAIT back to IDLE.
- Glitch rejection: a 2-cycle pulse on a[0] -> filtered input unchanged; FSM stays IDLE.
- Saturation and concurrency:
  - 4 entries -> count=3, full=1, ovf=1.
  - Then a lane0 entry and a lane1 exit completing in the same cycle -> count stays 3.
  - clr -> count=0, ovf=0.
- Timeout and reset:
  - Hold 10 for 60 cycles -> WAIT; a later 11,01,00 gives no pulse.
  - Separately, assert rst low mid-sequence -> all outputs return to reset values asynchronously.
